// File: rtl/ov7670_dvp_source.sv
// OV7670-style DVP pixel source: emits RGB444 test-pattern frames as two bytes per pixel,
// one byte per clock, with href/vsync framing matching the camera's parallel bus.
module ov7670_dvp_source #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic [1:0]  i_pattern,
    input  logic [11:0] i_solid,
    output logic [7:0]  o_pix_byte,
    output logic        o_href,
    output logic        o_vsync,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [7:0]  o_frame_cnt
);

    localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned BAR_W     = H_ACTIVE / 8;
    localparam int unsigned BAR_BYTES = 2 * BAR_W;
    localparam int unsigned COL_W     = $clog2(LINE_LEN);
    localparam int unsigned SUB_W     = (BAR_BYTES > 1) ? $clog2(BAR_BYTES) : 1;
    localparam int unsigned MAX_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int unsigned MAX_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned LN_W      = $clog2(MAX_LINES + 1);

    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0] HREF_COLS   = COL_W'(2 * H_ACTIVE);
    localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(BAR_BYTES - 1);
    localparam logic [LN_W-1:0]  VFRONT_LAST = LN_W'(V_FRONT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } state_e;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LN_W-1:0]    line_q, line_d;
    logic [LN_W-1:0]    last_line;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [2:0]         bar_q, bar_d;
    logic [1:0]         pat_q, pat_d;
    logic [11:0]        solid_q, solid_d;

    logic [7:0]         pix_byte_q, pix_byte_d;
    logic               href_q, href_d;
    logic               vsync_q, vsync_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [11:0]        pix;

    // Index of the final line of the current frame region.
    always_comb begin
        last_line = '0;
        unique case (state_q)
            StVsync:  last_line = LN_W'(VSYNC_LINES - 1);
            StVback:  last_line = LN_W'(V_BACK - 1);
            StActive: last_line = LN_W'(V_ACTIVE - 1);
            StVfront: last_line = VFRONT_LAST;
            default:  last_line = '0;
        endcase
    end

    // Frame sequencer: column/line counting and region transitions; pattern latched at frame start.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        if (state_q == StIdle) begin
            if (i_en) begin
                state_d = StVsync;
                col_d   = '0;
                line_d  = '0;
                pat_d   = i_pattern;
                solid_d = i_solid;
            end
        end else if (col_q != COL_LAST) begin
            col_d = col_q + COL_W'(1);
        end else begin
            col_d = '0;
            if (line_q != last_line) begin
                line_d = line_q + LN_W'(1);
            end else begin
                line_d = '0;
                unique case (state_q)
                    StVsync:  state_d = StVback;
                    StVback:  state_d = StActive;
                    StActive: state_d = StVfront;
                    StVfront: begin
                        if (i_en) begin
                            state_d = StVsync;
                            pat_d   = i_pattern;
                            solid_d = i_solid;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                    default:  state_d = StIdle;
                endcase
            end
        end
    end

    // Colour-bar index tracked by a byte sub-counter so no divider is needed.
    always_comb begin
        sub_d = sub_q;
        bar_d = bar_q;
        if (col_d == '0) begin
            sub_d = '0;
            bar_d = '0;
        end else if (sub_q == SUB_LAST) begin
            sub_d = '0;
            bar_d = bar_q + 3'd1;
        end else begin
            sub_d = sub_q + SUB_W'(1);
        end
    end

    // Output next-state: computed from the next counters so every output is a flop.
    always_comb begin
        href_d      = 1'b0;
        pix_byte_d  = 8'h00;
        vsync_d     = (state_d == StVsync);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StVfront) && (col_d == COL_LAST) && (line_d == VFRONT_LAST);
        frame_cnt_d = frame_cnt_q;
        if (done_d) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
        pix = 12'h000;
        unique case (pat_d)
            2'd0: begin
                unique case (bar_d)
                    3'd0: pix = 12'hFFF;
                    3'd1: pix = 12'hFF0;
                    3'd2: pix = 12'h0FF;
                    3'd3: pix = 12'h0F0;
                    3'd4: pix = 12'hF0F;
                    3'd5: pix = 12'hF00;
                    3'd6: pix = 12'h00F;
                    3'd7: pix = 12'h000;
                endcase
            end
            2'd1:    pix = 12'(col_d >> 1) + 12'(line_d);
            default: pix = solid_d;
        endcase
        if ((state_d == StActive) && (col_d < HREF_COLS)) begin
            href_d     = 1'b1;
            // Even column carries red, odd column carries green/blue.
            pix_byte_d = col_d[0] ? pix[7:0] : {4'h0, pix[11:8]};
        end
    end

    // Sequencer state registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            col_q   <= '0;
            line_q  <= '0;
            sub_q   <= '0;
            bar_q   <= '0;
            pat_q   <= '0;
            solid_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            sub_q   <= sub_d;
            bar_q   <= bar_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
        end
    end

    // Registered bus outputs and completed-frame counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pix_byte_q  <= 8'h00;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            pix_byte_q  <= pix_byte_d;
            href_q      <= href_d;
            vsync_q     <= vsync_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_pix_byte   = pix_byte_q;
    assign o_href       = href_q;
    assign o_vsync      = vsync_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_dvp_source.sv
// Bench for ov7670_dvp_source: a frame-time reference model pushes the expected bus state for
// each clock edge into a scoreboard; a negedge monitor pops and compares.
module tb_ov7670_dvp_source;

    localparam int H_ACTIVE    = 8;
    localparam int V_ACTIVE    = 3;
    localparam int H_BLANK     = 2;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME       = LINE_LEN * (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);

    logic        i_clk;
    logic        i_rstn;
    logic        i_en;
    logic [1:0]  i_pattern;
    logic [11:0] i_solid;
    logic [7:0]  o_pix_byte;
    logic        o_href;
    logic        o_vsync;
    logic        o_busy;
    logic        o_frame_done;
    logic [7:0]  o_frame_cnt;

    ov7670_dvp_source #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .H_BLANK    (H_BLANK),
        .VSYNC_LINES(VSYNC_LINES),
        .V_BACK     (V_BACK),
        .V_FRONT    (V_FRONT)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_en        (i_en),
        .i_pattern   (i_pattern),
        .i_solid     (i_solid),
        .o_pix_byte  (o_pix_byte),
        .o_href      (o_href),
        .o_vsync     (o_vsync),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done),
        .o_frame_cnt (o_frame_cnt)
    );

    typedef struct {
        int         tag;
        logic [7:0] pix;
        logic       href;
        logic       vsync;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_vec  = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    logic [11:0] bar_rgb [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                   12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // Reference model state: running flag, cycle within frame, latched pattern, frames done.
    bit          m_run = 0;
    int          m_t = 0;
    int          m_frames = 0;
    logic [1:0]  m_pat = '0;
    logic [11:0] m_sol = '0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Predict the outputs visible after the coming clock edge, given the inputs sampled there.
    task automatic model_step(input logic en, input logic [1:0] pat, input logic [11:0] sol);
        exp_t        e;
        int          line;
        int          col;
        int          act;
        int          x;
        logic [11:0] px;
        if (!m_run) begin
            if (en) begin
                m_run = 1;
                m_t   = 0;
                m_pat = pat;
                m_sol = sol;
            end
        end else if (m_t == FRAME - 1) begin
            if (en) begin
                m_t   = 0;
                m_pat = pat;
                m_sol = sol;
            end else begin
                m_run = 0;
            end
        end else begin
            m_t = m_t + 1;
        end
        e.pix   = 8'h00;
        e.href  = 1'b0;
        e.vsync = 1'b0;
        e.busy  = 1'b0;
        e.done  = 1'b0;
        if (m_run) begin
            line    = m_t / LINE_LEN;
            col     = m_t % LINE_LEN;
            act     = line - (VSYNC_LINES + V_BACK);
            e.busy  = 1'b1;
            e.vsync = (line < VSYNC_LINES);
            if (act >= 0 && act < V_ACTIVE && col < 2 * H_ACTIVE) begin
                x = col / 2;
                case (m_pat)
                    2'd0:    px = bar_rgb[x / (H_ACTIVE / 8)];
                    2'd1:    px = 12'((x + act) % 4096);
                    default: px = m_sol;
                endcase
                e.href = 1'b1;
                e.pix  = (col % 2 == 0) ? {4'h0, px[11:8]} : px[7:0];
            end
            if (m_t == FRAME - 1) begin
                e.done   = 1'b1;
                m_frames = (m_frames + 1) % 256;
            end
        end
        e.cnt = 8'(m_frames);
        e.tag = edge_cnt + 1;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic en, input logic [1:0] pat, input logic [11:0] sol);
        i_en      = en;
        i_pattern = pat;
        i_solid   = sol;
        model_step(en, pat, sol);
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check_val(name, int'({o_href, o_vsync, o_busy, o_frame_done, o_pix_byte, o_frame_cnt}), 0);
    endtask

    // Monitor: compare the DUT bus against the scoreboard entry for the most recent edge.
    always @(negedge i_clk) begin
        while (sb_q.size() > 0 && sb_q[0].tag < edge_cnt) begin
            mon_e  = sb_q.pop_front();
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_stale: got no check at edge %0d, expected one", mon_e.tag);
        end
        if (sb_q.size() > 0 && sb_q[0].tag == edge_cnt) begin
            mon_e = sb_q.pop_front();
            n_vec = n_vec + 1;
            if ({o_vsync, o_href, o_busy, o_frame_done, o_frame_cnt, o_pix_byte} !==
                {mon_e.vsync, mon_e.href, mon_e.busy, mon_e.done, mon_e.cnt, mon_e.pix}) begin
                n_fail = n_fail + 1;
                $display("FAIL bus@edge%0d: got vs=%b hr=%b bz=%b dn=%b cnt=%02h pix=%02h expected vs=%b hr=%b bz=%b dn=%b cnt=%02h pix=%02h",
                         edge_cnt, o_vsync, o_href, o_busy, o_frame_done, o_frame_cnt, o_pix_byte,
                         mon_e.vsync, mon_e.href, mon_e.busy, mon_e.done, mon_e.cnt, mon_e.pix);
            end
        end
    end

    initial begin
        logic en_r;
        i_rstn    = 1'b1;
        i_en      = 1'b0;
        i_pattern = 2'd0;
        i_solid   = 12'h000;
        #1 i_rstn = 1'b0;
        #2 check_zero("reset_hold");
        @(posedge i_clk);
        #1 i_rstn = 1'b1;

        // Idle with enable low.
        repeat (50) step(1'b0, 2'($urandom), 12'($urandom));
        check_zero("idle_50");

        // Colour bars; enable dropped at cycle 40, pattern inputs churn afterwards.
        repeat (40) step(1'b1, 2'd0, 12'($urandom));
        repeat (120) step(1'b0, 2'($urandom), 12'($urandom));

        // Ramp, enable held for exactly two back-to-back frames.
        repeat (2 * FRAME) step(1'b1, 2'd1, 12'($urandom));
        repeat (20) step(1'b0, 2'd1, 12'($urandom));

        // Solid colour; later changes to i_solid must not reach this frame.
        step(1'b1, 2'd2, 12'hA5C);
        repeat (FRAME + 10) step(1'b0, 2'($urandom), 12'($urandom));

        // Randomized enable bursts and pattern churn.
        en_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) en_r = ~en_r;
            step(en_r, 2'($urandom), 12'($urandom));
        end
        repeat (FRAME + 10) step(1'b0, 2'($urandom), 12'($urandom));

        // Reset in the middle of a frame.
        repeat (50) step(1'b1, 2'($urandom), 12'($urandom));
        #6 i_rstn = 1'b0;
        #1 check_zero("reset_mid_frame");
        repeat (3) @(posedge i_clk);
        #1 check_zero("reset_held");
        sb_q.delete();
        m_run    = 0;
        m_t      = 0;
        m_frames = 0;
        i_rstn   = 1'b1;
        repeat (20) step(1'b0, 2'($urandom), 12'($urandom));

        // 256 continuous frames: the completed-frame counter wraps to zero.
        repeat (256 * FRAME) step(1'b1, 2'($urandom), 12'($urandom));
        repeat (5) step(1'b0, 2'($urandom), 12'($urandom));
        check_val("frame_cnt_wrap", int'(o_frame_cnt), 0);
        check_val("busy_after_wrap", int'(o_busy), 0);

        #10;
        if (sb_q.size() != 0) begin
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
